// File: rtl/washer_pkg.sv
// Shared definitions for the wash machine controller and its phase timer.
package washer_pkg;

  typedef enum logic [1:0] {
    LOAD_S  = 2'b00,
    LOAD_M  = 2'b01,
    LOAD_L  = 2'b10,
    LOAD_XL = 2'b11
  } load_e;

  localparam int unsigned CW_DEF        = 8;
  localparam int unsigned PRESCALE_DEF  = 1;
  localparam int unsigned T_DRAIN_DEF   = 1;
  localparam int unsigned T_FILL_DEF    = 2;
  localparam int unsigned T_RINSE_DEF   = 4;
  localparam int unsigned T_SPIN_DEF    = 7;
  localparam int unsigned T_WASH_S_DEF  = 2;
  localparam int unsigned T_WASH_M_DEF  = 4;
  localparam int unsigned T_WASH_L_DEF  = 8;
  localparam int unsigned T_WASH_XL_DEF = 12;

  // True when a duration is representable by a non-zero count of width cw.
  function automatic bit t_fits(input int unsigned t, input int unsigned cw);
    return (t >= 1) && (64'(t) <= ((64'(1) << cw) - 64'(1)));
  endfunction

endpackage

// File: rtl/washer_prescaler.sv
// Divides enabled clock cycles into time ticks; pause holds the partial count.
module washer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic R,
  input  logic en,
  output logic tick
);

  // A 1-bit register that never leaves zero when PRESCALE=1; synthesis trims it.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          wrap;

  assign wrap = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (en) begin
      pre_d = wrap ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = en & ~R & wrap;

endmodule

// File: rtl/washer_timer_gen.sv
// Saturating elapsed-time counter per wash phase with threshold flags.
module washer_timer_gen
  import washer_pkg::*;
#(
  parameter int unsigned CW        = CW_DEF,
  parameter int unsigned PRESCALE  = PRESCALE_DEF,
  parameter int unsigned T_DRAIN   = T_DRAIN_DEF,
  parameter int unsigned T_FILL    = T_FILL_DEF,
  parameter int unsigned T_RINSE   = T_RINSE_DEF,
  parameter int unsigned T_SPIN    = T_SPIN_DEF,
  parameter int unsigned T_WASH_S  = T_WASH_S_DEF,
  parameter int unsigned T_WASH_M  = T_WASH_M_DEF,
  parameter int unsigned T_WASH_L  = T_WASH_L_DEF,
  parameter int unsigned T_WASH_XL = T_WASH_XL_DEF
) (
  input  logic          clk,
  input  logic          R,
  input  logic          en,
  input  logic [1:0]    load,
  output logic          Td,
  output logic          Tf,
  output logic          Tr,
  output logic          Ts,
  output logic          Tw,
  output logic          tick,
  output logic [CW-1:0] count,
  output logic          ovf
);

  if (CW < 3) begin : g_bad_cw
    $fatal(1, "washer_timer_gen: CW must be >= 3");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "washer_timer_gen: PRESCALE must be >= 1");
  end
  if (!t_fits(T_DRAIN, CW) || !t_fits(T_FILL, CW) || !t_fits(T_RINSE, CW) ||
      !t_fits(T_SPIN, CW) || !t_fits(T_WASH_S, CW) || !t_fits(T_WASH_M, CW) ||
      !t_fits(T_WASH_L, CW) || !t_fits(T_WASH_XL, CW)) begin : g_bad_t
    $fatal(1, "washer_timer_gen: every T_* must lie in 1..2^CW-1");
  end

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  load_e         load_q;
  logic [CW-1:0] wash_thr;
  logic          tick_c;

  washer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .R    (R),
    .en   (en),
    .tick (tick_c)
  );

  // Saturate rather than wrap; ovf latches once the top value is reached.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (tick_c) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CW'(1);
      end
      if (count_q >= (CNT_MAX - CW'(1))) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Restart clears the run and re-latches the load size.
  always_ff @(posedge clk) begin
    if (R) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      load_q  <= load_e'(load);
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    wash_thr = CW'(T_WASH_S);
    case (load_q)
      LOAD_S:  wash_thr = CW'(T_WASH_S);
      LOAD_M:  wash_thr = CW'(T_WASH_M);
      LOAD_L:  wash_thr = CW'(T_WASH_L);
      LOAD_XL: wash_thr = CW'(T_WASH_XL);
      default: wash_thr = CW'(T_WASH_S);
    endcase
  end

  assign Td    = (count_q >= CW'(T_DRAIN));
  assign Tf    = (count_q >= CW'(T_FILL));
  assign Tr    = (count_q >= CW'(T_RINSE));
  assign Ts    = (count_q >= CW'(T_SPIN));
  assign Tw    = (count_q >= wash_thr);
  assign tick  = tick_c;
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_washer_timer_gen.sv
// Bench for washer_timer_gen: default, PRESCALE=3 and CW=4 instances share stimulus.
module tb_washer_timer_gen;

  typedef struct packed {
    logic [7:0] cnt;
    logic       td, tf, tr, ts, tw, tk, ov;
  } obs_t;

  typedef logic [3*$bits(obs_t)-1:0] obs3_t;

  logic       clk;
  logic       R, en;
  logic [1:0] load;

  logic       td_a, tf_a, tr_a, ts_a, tw_a, tk_a, ov_a;
  logic [7:0] cnt_a;
  logic       td_b, tf_b, tr_b, ts_b, tw_b, tk_b, ov_b;
  logic [7:0] cnt_b;
  logic       td_c, tf_c, tr_c, ts_c, tw_c, tk_c, ov_c;
  logic [3:0] cnt_c;

  washer_timer_gen dut_a (
    .clk(clk), .R(R), .en(en), .load(load),
    .Td(td_a), .Tf(tf_a), .Tr(tr_a), .Ts(ts_a), .Tw(tw_a),
    .tick(tk_a), .count(cnt_a), .ovf(ov_a)
  );

  washer_timer_gen #(.PRESCALE(3)) dut_b (
    .clk(clk), .R(R), .en(en), .load(load),
    .Td(td_b), .Tf(tf_b), .Tr(tr_b), .Ts(ts_b), .Tw(tw_b),
    .tick(tk_b), .count(cnt_b), .ovf(ov_b)
  );

  washer_timer_gen #(.CW(4)) dut_c (
    .clk(clk), .R(R), .en(en), .load(load),
    .Td(td_c), .Tf(tf_c), .Tr(tr_c), .Ts(ts_c), .Tw(tw_c),
    .tick(tk_c), .count(cnt_c), .ovf(ov_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs3_t       sb[$];
  int unsigned k;      // enabled cycles since the last restart
  logic [1:0]  lq;     // load size the bench expects to be latched
  int          cyc;
  int          n_checks;
  int          n_fail;

  function automatic int unsigned wash_of(input logic [1:0] l);
    case (l)
      2'b00:   return 2;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 12;
    endcase
  endfunction

  function automatic obs_t exp_one(input int unsigned p, input int unsigned maxv,
                                   input logic r, input logic e);
    obs_t        o;
    int unsigned c;
    c    = ((k / p) > maxv) ? maxv : (k / p);
    o.cnt = 8'(c);
    o.td  = (c >= 1);
    o.tf  = (c >= 2);
    o.tr  = (c >= 4);
    o.ts  = (c >= 7);
    o.tw  = (c >= wash_of(lq));
    o.tk  = e & ~r & ((k % p) == (p - 1));
    o.ov  = ((k / p) >= maxv);
    return o;
  endfunction

  function automatic obs3_t observe();
    obs_t a, b, c;
    a = '{cnt: cnt_a, td: td_a, tf: tf_a, tr: tr_a, ts: ts_a, tw: tw_a, tk: tk_a, ov: ov_a};
    b = '{cnt: cnt_b, td: td_b, tf: tf_b, tr: tr_b, ts: ts_b, tw: tw_b, tk: tk_b, ov: ov_b};
    c = '{cnt: {4'b0, cnt_c}, td: td_c, tf: tf_c, tr: tr_c, ts: ts_c, tw: tw_c, tk: tk_c, ov: ov_c};
    return {a, b, c};
  endfunction

  // Applies one cycle of stimulus and queues the state expected after that edge.
  task automatic drive(input logic r, input logic e, input logic [1:0] ld);
    R    = r;
    en   = e;
    load = ld;
    if (r) begin
      k  = 0;
      lq = ld;
    end else if (e) begin
      k++;
    end
    sb.push_back({exp_one(1, 255, r, e), exp_one(3, 255, r, e), exp_one(1, 15, r, e)});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    obs3_t got, expv;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b01);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
    end
  endtask

  task automatic test_phases();
    obs3_t got, expv;
    drive(1'b1, 1'b0, 2'b01);
    got = observe(); expv = sb.pop_front(); n_checks++;
    if (got !== expv) begin
      n_fail++; $display("FAIL phases_r cyc=%0d got=%h exp=%h", cyc, got, expv);
    end
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 2'b01);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL phases cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
      if (i == 7) begin
        n_checks++;
        if (cnt_a !== 8'd7 || ts_a !== 1'b1) begin
          n_fail++; $display("FAIL phases_t7 count=%0d Ts=%b exp count=7 Ts=1", cnt_a, ts_a);
        end
      end
    end
  endtask

  task automatic test_prescale_pause();
    obs3_t got, expv;
    drive(1'b1, 1'b0, 2'b00);
    got = observe(); expv = sb.pop_front(); n_checks++;
    if (got !== expv) begin
      n_fail++; $display("FAIL pre_r cyc=%0d got=%h exp=%h", cyc, got, expv);
    end
    for (int i = 1; i <= 24; i++) begin
      // cycles 11..20 pause at count=3 with one partial tick held
      logic e;
      e = !(i >= 11 && i <= 20);
      drive(1'b0, e, 2'($urandom_range(0, 3)));
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL prescale cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
      if (i == 6) begin
        n_checks++;
        if (cnt_b !== 8'd2 || tf_b !== 1'b1) begin
          n_fail++; $display("FAIL pre_t6 count=%0d Tf=%b exp count=2 Tf=1", cnt_b, tf_b);
        end
      end
      if (i == 21) begin
        n_checks++;
        if (tk_b !== 1'b1 || cnt_b !== 8'd3) begin
          n_fail++; $display("FAIL resume tick=%b count=%0d exp tick=1 count=3", tk_b, cnt_b);
        end
      end
    end
  endtask

  task automatic test_saturation();
    obs3_t got, expv;
    drive(1'b1, 1'b1, 2'b10);
    void'(sb.pop_front());
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b1, 2'b10);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL saturate cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
    end
    n_checks++;
    if (cnt_c !== 4'd15 || ov_c !== 1'b1) begin
      n_fail++; $display("FAIL sat_end count=%0d ovf=%b exp count=15 ovf=1", cnt_c, ov_c);
    end
    drive(1'b1, 1'b1, 2'b10);
    got = observe(); expv = sb.pop_front(); n_checks++;
    if (got !== expv) begin
      n_fail++; $display("FAIL sat_clear cyc=%0d got=%h exp=%h", cyc, got, expv);
    end
  endtask

  task automatic test_load_latch();
    obs3_t got, expv;
    drive(1'b1, 1'b1, 2'b00);
    void'(sb.pop_front());
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 2'b10);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL load_s cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
      if (i == 2) begin
        n_checks++;
        if (tw_a !== 1'b1) begin
          n_fail++; $display("FAIL load_s_tw Tw=%b at count=%0d exp 1", tw_a, cnt_a);
        end
      end
    end
    drive(1'b1, 1'b1, 2'b11);
    void'(sb.pop_front());
    for (int i = 1; i <= 13; i++) begin
      drive(1'b0, 1'b1, 2'b00);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL load_xl cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
      if (i == 11 || i == 12) begin
        n_checks++;
        if (tw_a !== (i == 12)) begin
          n_fail++; $display("FAIL load_xl_tw Tw=%b at count=%0d exp %b", tw_a, cnt_a, (i == 12));
        end
      end
    end
  endtask

  task automatic test_r_on_tick();
    obs3_t got, expv;
    drive(1'b1, 1'b1, 2'b01);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 2'b01);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b01);
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL r_tick cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
      n_checks++;
      if (cnt_a !== 8'd0 || td_a !== 1'b0) begin
        n_fail++; $display("FAIL r_tick_cnt count=%0d Td=%b exp 0 0", cnt_a, td_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs3_t got, expv;
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)));
      got = observe(); expv = sb.pop_front(); n_checks++;
      if (got !== expv) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, expv);
      end
    end
  endtask

  initial begin
    R = 1'b1; en = 1'b0; load = 2'b00;
    k = 0; lq = 2'b00; cyc = 0; n_checks = 0; n_fail = 0;
    test_reset();
    test_phases();
    test_prescale_pause();
    test_saturation();
    test_load_latch();
    test_r_on_tick();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_timer_gen.md
Name: washer_timer_gen

Overview:
Parametrised phase timer for the wash machine controller; successor to the fixed 4-bit washer timer.
- One free-running elapsed-time counter per phase, cleared by the controller FSM at each phase entry.
- Adds: prescaled time base, pause (en), saturation instead of wrap, sticky "elapsed" flags, load latched at restart, and a 4th load size.
- Sits between the controller FSM (drives R, en, load) and its transition logic (consumes Td/Tf/Tr/Ts/Tw).

Parameters:
CW, 8, counter width in bits (>=3)
PRESCALE, 1, clk cycles per time tick (>=1); 1 = count every enabled cycle
T_DRAIN, 1, ticks until Td
T_FILL, 2, ticks until Tf
T_RINSE, 4, ticks until Tr
T_SPIN, 7, ticks until Ts
T_WASH_S, 2, wash ticks, load 2'b00
T_WASH_M, 4, wash ticks, load 2'b01
T_WASH_L, 8, wash ticks, load 2'b10
T_WASH_XL, 12, wash ticks, load 2'b11
All T_* must be in 1..2^CW-1; elaboration-time check, fatal otherwise.

Ports:
clk  in  1  system clock, all state on posedge
R  in  1  synchronous active-high reset/restart; clears timer state
en  in  1  count enable; 0 = pause (lid open), state held
load  in  2  load size; sampled only while R=1
Td  out  1  drain time elapsed
Tf  out  1  fill time elapsed
Tr  out  1  rinse time elapsed
Ts  out  1  spin time elapsed
Tw  out  1  wash time elapsed for latched load
tick  out  1  one-cycle pulse, counter advances this edge
count  out  CW  current elapsed ticks
ovf  out  1  sticky: counter reached saturation (all ones)

Behaviour:
- Reset: one clock; synchronous, active-high, on R. R=1 at posedge sets:
  - pre <= 0, count <= 0, ovf <= 0, load_q <= load.
  - Outputs during and after R: Td=Tf=Tr=Ts=Tw=0, tick=0, count=0, ovf=0.
- R dominates en. R held high keeps the block cleared and keeps re-sampling load.
- Prescaler: pre is a register of width clog2(PRESCALE), or absent when PRESCALE=1.
  - tick = en & ~R & (pre == PRESCALE-1); combinational from registers and inputs.
  - If en & ~R: pre <= (pre == PRESCALE-1) ? 0 : pre+1.
  - en=0: pre holds (pause does not lose partial tick).
- Counter, on tick:
  - If count != all-ones: count <= count+1.
  - If count == all-ones: count holds and ovf <= 1.
  - ovf also sets on the tick that makes count all-ones.
  - No wrap-around, ever.
- Flags: combinational from registered count and load_q:
  - Td = (count >= T_DRAIN), Tf = (count >= T_FILL), Tr = (count >= T_RINSE), Ts = (count >= T_SPIN).
  - Tw = (count >= T_WASH_x), x selected by load_q.
  - Flags stay high until R (sticky via monotonic count). Pause does not clear them.
- Latency: a flag rises in the cycle after the posedge where count reaches its threshold. With PRESCALE=1 and en held, this is the Tth cycle after R deasserts.
- load changes while R=0 are ignored. load_q updates only on R.
- Simultaneous R and tick: R wins; count=0, no increment.
- en toggling mid-prescale: pre resumes from its held value.

Decomposition:
- Shared package washer_pkg:
  - load encoding constants LOAD_S/M/L/XL = 2'b00..2'b11.
  - Default phase durations.
  - The controller FSM uses the same names.
- One natural sub-module: washer_prescaler (PRESCALE param; en, R in; tick out).
- Compare logic stays inline.

Test Plan:
- Defaults; R 1 cycle, load=2'b01, en=1 -> Td high 1 cycle after first tick (count=1), Tf at count=2, Tw at count=4, Tr at 4, Ts at 7; all stay high; count=7 after 7 cycles.
- PRESCALE=3; en=1 -> tick every 3rd cycle; count=2 after 6 cycles post-R; Tf rises then.
- Pause: en=0 at count=3 with pre=1 for 10 cycles -> count, pre, flags frozen; resume -> next tick after exactly 1 enabled cycle.
- CW=4; run 20 cycles -> count saturates at 15, ovf=1 from that tick on, no wrap to 0; R -> ovf=0, count=0.
- load=2'b00 latched at R, then load driven to 2'b10 mid-run -> Tw at count=2, not 8. Next R with load=2'b11 -> Tw at count=12.
- R asserted on the same edge as a tick at count=5 -> count=0, all flags 0 next cycle; R held 3 cycles -> count stays 0.
